// File: rtl/mem_responder_if.sv
// Bus and UART-side signal bundle for mem_responder.
// The slave modport is the responder's view; the master modport is the
// environment that drives the initiator side and both UART endpoints.
interface mem_responder_if;
    logic        rdy_in;
    logic [31:0] byte_a;
    logic [7:0]  byte_din;
    logic        byte_wr;
    logic [7:0]  byte_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport slave (
        input  rdy_in,
        input  byte_a,
        input  byte_din,
        input  byte_wr,
        output byte_dout,
        output io_buffer_full,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

    modport master (
        output rdy_in,
        output byte_a,
        output byte_din,
        output byte_wr,
        input  byte_dout,
        input  io_buffer_full,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        input  rx_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory responder: single-cycle pipelined RAM plus a small IO
// window exposing a TX FIFO (towards a UART sink), an RX FIFO (from a UART
// source) and a status/overflow register.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH       = 17,
    parameter int unsigned FIFO_DEPTH_WIDTH = 3
) (
    input  logic           clk_in,
    input  logic           rst_in,
    mem_responder_if.slave bus
);

    localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int unsigned DEPTH     = 1 << FIFO_DEPTH_WIDTH;
    localparam int unsigned PW        = FIFO_DEPTH_WIDTH;
    localparam int unsigned CW        = FIFO_DEPTH_WIDTH + 1;

    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_NEAR  = CW'(DEPTH - 1);
    localparam logic [15:0]   OFF_DATA  = 16'h0000;
    localparam logic [15:0]   OFF_STAT  = 16'h0004;

    // Storage (never reset)
    logic [7:0] ram_q    [RAM_BYTES];
    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];

    // FIFO state
    logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;

    // Sticky flags and registered outputs
    logic       tx_ovf_q, tx_ovf_d;
    logic       rx_ovf_q, rx_ovf_d;
    logic [7:0] byte_dout_q, byte_dout_d;
    logic       io_full_q, io_full_d;

    // Decode and strobes
    logic                  io_sel_c;
    logic [15:0]           io_off_c;
    logic [ADDR_WIDTH-1:0] ram_idx_c;
    logic                  ram_wr_c;
    logic                  tx_push_req_c;
    logic                  tx_push_ok_c;
    logic                  tx_pop_c;
    logic                  rx_pop_c;
    logic                  rx_push_ok_c;
    logic                  ovf_clr_c;
    logic                  tx_nonempty_c;
    logic                  rx_nonempty_c;
    logic [7:0]            status_c;
    logic                  unused_addr_c;

    // Address decode; bits above the IO select are don't-care
    assign io_sel_c      = (bus.byte_a[17:16] == 2'b11);
    assign io_off_c      = bus.byte_a[15:0];
    assign ram_idx_c     = bus.byte_a[ADDR_WIDTH-1:0];
    assign unused_addr_c = ^bus.byte_a[31:18];

    assign tx_nonempty_c = (tx_cnt_q != '0);
    assign rx_nonempty_c = (rx_cnt_q != '0);

    // Bus-side strobes are all qualified by rdy_in; UART sides are not
    assign ram_wr_c      = bus.rdy_in && bus.byte_wr && !io_sel_c;
    assign tx_push_req_c = bus.rdy_in && bus.byte_wr && io_sel_c && (io_off_c == OFF_DATA);
    assign ovf_clr_c     = bus.rdy_in && bus.byte_wr && io_sel_c && (io_off_c == OFF_STAT);
    assign rx_pop_c      = bus.rdy_in && !bus.byte_wr && io_sel_c && (io_off_c == OFF_DATA)
                           && rx_nonempty_c;

    // TX pops only on a real handshake, so an empty FIFO never pops
    assign tx_pop_c      = tx_nonempty_c && bus.tx_ready;
    // A full FIFO still accepts when a slot frees up in the same cycle
    assign tx_push_ok_c  = tx_push_req_c && ((tx_cnt_q < CNT_DEPTH) || tx_pop_c);
    assign rx_push_ok_c  = bus.rx_valid && ((rx_cnt_q < CNT_DEPTH) || rx_pop_c);

    assign status_c = {4'b0000, rx_ovf_q, tx_ovf_q, rx_nonempty_c, (tx_cnt_q == CNT_DEPTH)};

    // Outputs
    assign bus.byte_dout      = byte_dout_q;
    assign bus.io_buffer_full = io_full_q;
    assign bus.tx_data        = tx_mem_q[tx_rd_q];
    assign bus.tx_valid       = tx_nonempty_c;
    assign bus.rx_ready       = (rx_cnt_q < CNT_DEPTH);

    // FIFO pointer/count and sticky flag next-state
    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;

        if (tx_push_ok_c) tx_wr_d = tx_wr_q + PW'(1);
        if (tx_pop_c)     tx_rd_d = tx_rd_q + PW'(1);
        if (rx_push_ok_c) rx_wr_d = rx_wr_q + PW'(1);
        if (rx_pop_c)     rx_rd_d = rx_rd_q + PW'(1);

        tx_cnt_d = tx_cnt_q + CW'(tx_push_ok_c) - CW'(tx_pop_c);
        rx_cnt_d = rx_cnt_q + CW'(rx_push_ok_c) - CW'(rx_pop_c);

        // Clear first so a same-cycle overflow event wins
        if (ovf_clr_c) begin
            tx_ovf_d = 1'b0;
            rx_ovf_d = 1'b0;
        end
        if (tx_push_req_c && !tx_push_ok_c) tx_ovf_d = 1'b1;
        if (bus.rx_valid && !rx_push_ok_c)  rx_ovf_d = 1'b1;

        // One in-flight write of margin before the FIFO is actually full
        io_full_d = (tx_cnt_d >= CNT_NEAR);
    end

    // Read-data mux: RAM read-before-write, or IO register/FIFO head
    always_comb begin
        byte_dout_d = byte_dout_q;
        if (bus.rdy_in) begin
            if (!io_sel_c) begin
                byte_dout_d = ram_q[ram_idx_c];
            end else if (!bus.byte_wr) begin
                unique case (io_off_c)
                    OFF_DATA: byte_dout_d = rx_nonempty_c ? rx_mem_q[rx_rd_q] : 8'h00;
                    OFF_STAT: byte_dout_d = status_c;
                    default:  byte_dout_d = 8'h00;
                endcase
            end else begin
                byte_dout_d = 8'h00;
            end
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            byte_dout_q <= 8'h00;
            io_full_q   <= 1'b0;
        end else begin
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovf_q    <= rx_ovf_d;
            byte_dout_q <= byte_dout_d;
            io_full_q   <= io_full_d;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (!rst_in && ram_wr_c) begin
            ram_q[ram_idx_c] <= bus.byte_din;
        end
    end

    // FIFO data storage
    always_ff @(posedge clk_in) begin
        if (!rst_in && tx_push_ok_c) begin
            tx_mem_q[tx_wr_q] <= bus.byte_din;
        end
        if (!rst_in && rx_push_ok_c) begin
            rx_mem_q[rx_wr_q] <= bus.rx_data;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: read data and TX drain bytes are
// predicted into queues as stimulus is driven and compared as they appear.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] rd_exp_q [$];
    logic [7:0] tx_exp_q [$];

    mem_responder_if bus_if();

    mem_responder #(
        .ADDR_WIDTH      (17),
        .FIFO_DEPTH_WIDTH(3)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle; optional read expectation checked one cycle later
    task automatic bus_op(input logic wr, input logic [31:0] a, input logic [7:0] d,
                          input bit do_chk, input logic [7:0] exp, input string tag);
        bus_if.byte_wr  = wr;
        bus_if.byte_a   = a;
        bus_if.byte_din = d;
        if (do_chk) rd_exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (do_chk) chk(tag, 32'(bus_if.byte_dout), 32'(rd_exp_q.pop_front()));
    endtask

    task automatic idle(input int n);
        repeat (n) bus_op(1'b0, 32'h0, 8'h00, 1'b0, 8'h00, "idle");
    endtask

    // TX sink: compare each handshaken byte against the predicted order
    always @(negedge clk) begin
        if (!rst && bus_if.tx_valid && bus_if.tx_ready) begin
            if (tx_exp_q.size() == 0) chk("tx_extra", 32'(tx_exp_q.size()), 32'd1);
            else                      chk("tx_drain", 32'(bus_if.tx_data), 32'(tx_exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus_if.rdy_in   = 1'b1;
        bus_if.byte_a   = 32'h0;
        bus_if.byte_din = 8'h00;
        bus_if.byte_wr  = 1'b0;
        bus_if.tx_ready = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;

        // Reset state
        idle(2);
        chk("rst_dout", 32'(bus_if.byte_dout), 32'h00);
        chk("rst_iobf", 32'(bus_if.io_buffer_full), 32'h0);
        chk("rst_txv", 32'(bus_if.tx_valid), 32'h0);
        chk("rst_rxr", 32'(bus_if.rx_ready), 32'h1);
        rst = 1'b0;
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h00, "rst_status");

        // Write then read next cycle
        bus_op(1'b1, 32'h00010, 8'hA5, 1'b0, 8'h00, "");
        bus_op(1'b0, 32'h00010, 8'h00, 1'b1, 8'hA5, "wr_rd");

        // Back-to-back pipelined reads
        for (int i = 0; i < 4; i++) bus_op(1'b1, 32'h100 + 32'(i), 8'(8'h11 * (i + 1)), 1'b0, 8'h00, "");
        for (int i = 0; i < 4; i++) bus_op(1'b0, 32'h100 + 32'(i), 8'h00, 1'b1, 8'(8'h11 * (i + 1)), "b2b");

        // Read-before-write on the same address
        bus_op(1'b1, 32'h100, 8'h99, 1'b1, 8'h11, "rbw_old");
        bus_op(1'b0, 32'h100, 8'h00, 1'b1, 8'h99, "rbw_new");

        // Decode boundaries: 0x2xxxx is RAM (aliases via index), top RAM byte, unmapped IO
        bus_op(1'b1, 32'h20010, 8'h3C, 1'b0, 8'h00, "");
        bus_op(1'b0, 32'h00010, 8'h00, 1'b1, 8'h3C, "alias");
        bus_op(1'b1, 32'h1FFFF, 8'h5E, 1'b0, 8'h00, "");
        bus_op(1'b0, 32'h1FFFF, 8'h00, 1'b1, 8'h5E, "ram_top");
        bus_op(1'b1, 32'h30008, 8'hFF, 1'b0, 8'h00, "");
        bus_op(1'b0, 32'h30008, 8'h00, 1'b1, 8'h00, "io_unmapped");

        // TX fill with sink stalled: near-full after 7th, 9th dropped
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) tx_exp_q.push_back(8'(8'h40 + k));
            bus_op(1'b1, 32'h30000, 8'(8'h40 + k), 1'b0, 8'h00, "");
            chk("iobf_fill", 32'(bus_if.io_buffer_full), 32'(k >= 7));
        end
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h05, "tx_ovf_status");
        bus_op(1'b1, 32'h30004, 8'hFF, 1'b0, 8'h00, "");
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h01, "ovf_cleared");

        // Push into a full FIFO while it pops: accepted, no overflow
        bus_if.tx_ready = 1'b1;
        tx_exp_q.push_back(8'h4A);
        bus_op(1'b1, 32'h30000, 8'h4A, 1'b0, 8'h00, "");
        chk("iobf_full_pp", 32'(bus_if.io_buffer_full), 32'h1);
        idle(10);
        chk("tx_empty", 32'(bus_if.tx_valid), 32'h0);
        chk("iobf_empty", 32'(bus_if.io_buffer_full), 32'h0);
        chk("tx_all_out", 32'(tx_exp_q.size()), 32'd0);
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h00, "status_idle");

        // RX single byte then read twice
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h5A;
        idle(1);
        bus_if.rx_valid = 1'b0;
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h02, "rx_ne");
        bus_op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h5A, "rx_pop");
        bus_op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rx_empty_rd");
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h00, "rx_status_0");

        // RX fill, push-with-pop when full, overflow set beating clear
        bus_if.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_if.rx_data = 8'(8'h80 + i);
            idle(1);
        end
        chk("rx_full_rdy", 32'(bus_if.rx_ready), 32'h0);
        bus_if.rx_data = 8'h88;
        bus_op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h80, "rx_pop_full");
        bus_if.rx_data = 8'h89;
        bus_op(1'b1, 32'h30004, 8'h00, 1'b0, 8'h00, "");
        bus_if.rx_valid = 1'b0;
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h0A, "rx_ovf_setwin");
        for (int i = 1; i <= 8; i++) bus_op(1'b0, 32'h30000, 8'h00, 1'b1, 8'(8'h80 + i), "rx_order");
        bus_op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rx_drained");
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h08, "rx_ovf_sticky");
        bus_op(1'b1, 32'h30004, 8'h00, 1'b0, 8'h00, "");
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h00, "rx_ovf_clr");

        // rdy_in low: no RAM write, no bus pop, dout held; RX side still fills
        bus_op(1'b1, 32'h200, 8'h12, 1'b0, 8'h00, "");
        bus_op(1'b0, 32'h200, 8'h00, 1'b1, 8'h12, "pre_stall");
        bus_if.rdy_in   = 1'b0;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h33;
        bus_op(1'b1, 32'h200, 8'hEE, 1'b1, 8'h12, "stall_hold");
        bus_if.rx_valid = 1'b0;
        bus_op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h12, "stall_io");
        bus_if.rdy_in = 1'b1;
        bus_op(1'b0, 32'h200, 8'h00, 1'b1, 8'h12, "ram_kept");
        bus_op(1'b0, 32'h30000, 8'h00, 1'b1, 8'h33, "rx_during_stall");

        // Reset with both FIFOs holding data
        bus_if.tx_ready = 1'b0;
        bus_op(1'b1, 32'h30000, 8'h71, 1'b0, 8'h00, "");
        bus_op(1'b1, 32'h30000, 8'h72, 1'b0, 8'h00, "");
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h44;
        idle(1);
        bus_if.rx_valid = 1'b0;
        chk("pre_rst_txv", 32'(bus_if.tx_valid), 32'h1);
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h02, "pre_rst_status");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_txv", 32'(bus_if.tx_valid), 32'h0);
        chk("mid_rst_rxr", 32'(bus_if.rx_ready), 32'h1);
        chk("mid_rst_dout", 32'(bus_if.byte_dout), 32'h00);
        bus_op(1'b0, 32'h30004, 8'h00, 1'b1, 8'h00, "post_rst_status");

        chk("sb_empty", 32'(rd_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: RAM index width; RAM holds 2^ADDR_WIDTH bytes.
REQ-002 Parameter FIFO_DEPTH_WIDTH, default 3: TX and RX FIFO depth is 2^FIFO_DEPTH_WIDTH (8) entries each.
REQ-003 clk_in  input  1  single clock; all state updates on posedge.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 rdy_in  input  1  bus-side enable; low freezes bus-side state.
REQ-006 byte_a  input  32  byte address from the initiator.
REQ-007 byte_din  input  8  write data.
REQ-008 byte_wr  input  1  1 = write, 0 = read.
REQ-009 byte_dout  output  8  registered read data.
REQ-010 io_buffer_full  output  1  registered TX FIFO near-full flag.
REQ-011 tx_data  output  8  TX FIFO head byte.
REQ-012 tx_valid  output  1  TX FIFO non-empty.
REQ-013 tx_ready  input  1  UART sink accepts tx_data.
REQ-014 rx_data  input  8  byte from the UART source.
REQ-015 rx_valid  input  1  rx_data present.
REQ-016 rx_ready  output  1  RX FIFO not full.

Function
REQ-017 Decode: byte_a[17:16]==2'b11 SHALL select the IO region; otherwise RAM, indexed by byte_a[ADDR_WIDTH-1:0].
REQ-018 RAM write: with rdy_in=1, byte_wr=1 and RAM selected, mem[index] SHALL take byte_din at posedge.
REQ-019 RAM read: with rdy_in=1 and RAM selected, byte_dout SHALL take the pre-write mem[index] at posedge (1-cycle latency, read-before-write); this also applies when byte_wr=1.
REQ-020 Pipelining: a new address SHALL be accepted every cycle, with no bubbles.
REQ-021 IO write 0x30000: push byte_din into TX FIFO if accepted; if not accepted, drop the byte and set sticky tx_overflow.
REQ-022 IO write 0x30004: clear tx_overflow and rx_overflow; the data value is ignored.
REQ-023 IO read 0x30000: if RX FIFO non-empty, byte_dout <= RX head and pop; else byte_dout <= 8'h00, no pop.
REQ-024 IO read 0x30004: byte_dout <= {4'b0, rx_overflow, tx_overflow, rx_nonempty, tx_full}.
REQ-025 Other IO addresses: reads SHALL return 8'h00 and writes SHALL be ignored.
REQ-026 TX drain: tx_valid = TX non-empty; tx_data = head; pop when tx_valid && tx_ready.
REQ-027 TX push acceptance: the push SHALL be accepted if count < depth, or if count == depth with a pop in the same cycle; the count then stays at depth.
REQ-028 Simultaneous TX push and pop: both SHALL take effect, count unchanged, FIFO order preserved; an empty FIFO with push and pop SHALL NOT pop, since tx_valid=0.
REQ-029 io_buffer_full SHALL be registered, equal to (next TX count >= depth-1), giving one in-flight write of margin.
REQ-030 RX fill: rx_ready = RX count < depth; when rx_valid=1 and the FIFO is full, drop the byte and set sticky rx_overflow.
REQ-031 RX push concurrent with a bus pop when full: the pop SHALL free a slot and the push SHALL be accepted.
REQ-032 rdy_in=0: no RAM write, no bus-side FIFO push/pop, byte_dout held; the UART sides (tx pop, rx push) SHALL continue.
REQ-033 FIFO pointers SHALL wrap modulo depth; count SHALL be FIFO_DEPTH_WIDTH+1 bits wide.
REQ-034 Overflow clear (REQ-022) in the same cycle as a new overflow event: the set SHALL win.

Reset
REQ-035 On rst_in=1 at posedge: byte_dout=0, io_buffer_full=0, tx_valid=0, rx_ready=1, both FIFOs empty, both overflow flags 0.
REQ-036 RAM contents SHALL NOT be reset; reset mid-operation SHALL discard FIFO contents and any pending read.
REQ-037 rst_in SHALL override rdy_in.

Verification
REQ-038 Write 8'hA5 to 0x00010, then read 0x00010 the next cycle -> byte_dout=8'hA5 one cycle after the read address.
REQ-039 Read back-to-back at 0x100-0x103 holding 11,22,33,44 -> byte_dout 11,22,33,44 on consecutive cycles.
REQ-040 tx_ready=0, write 0x41..0x48 to 0x30000 -> io_buffer_full rises after the 7th write; 9th write dropped; status bit2=1; tx drain yields 0x41..0x48 in order.
REQ-041 Push 0x5A via rx, then read 0x30000 twice -> 8'h5A, then 8'h00; status bit1 0 after the pop.
REQ-042 rdy_in=0 during a RAM write -> memory unchanged and byte_dout held; resume -> normal operation.
REQ-043 Assert rst_in with both FIFOs holding data -> next cycle tx_valid=0, rx_ready=1, status=8'h00.
